// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a fixed-latency IDLE/RUN FSM.
// Optional accumulate ops (madd/maddu) are compiled in when MDU_MADD_EN is defined.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] tmp_hi_q, tmp_lo_q;
  logic        tmp_wr_q;

  // Odd opcodes (multu, divu, maddu) are the unsigned variants.
  logic        is_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quot, rem;

  assign is_signed = ~md_op[0];
  assign mul_a     = {{32{is_signed & A[31]}}, A};
  assign mul_b     = {{32{is_signed & B[31]}}, B};
  assign prod      = mul_a * mul_b;

  // Divide magnitudes, then restore signs; 0x80000000 / -1 wraps to 0x80000000 naturally.
  assign dvd_mag = (is_signed && A[31]) ? (~A + 32'd1) : A;
  assign dvs_mag = (is_signed && B[31]) ? (~B + 32'd1) : B;
  assign q_mag   = (dvs_mag == 32'd0) ? 32'd0 : dvd_mag / dvs_mag;
  assign r_mag   = (dvs_mag == 32'd0) ? 32'd0 : dvd_mag % dvs_mag;
  assign quot    = (is_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = (is_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      tmp_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'b000, 3'b001: begin
                tmp_hi_q <= prod[63:32];
                tmp_lo_q <= prod[31:0];
                tmp_wr_q <= 1'b1;
                cnt_q    <= MULT_LAT;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              3'b010, 3'b011: begin
                tmp_hi_q <= rem;
                tmp_lo_q <= quot;
                tmp_wr_q <= (B != 32'd0);
                cnt_q    <= DIV_LAT;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              3'b100: hi_q <= A;
              3'b101: lo_q <= A;
`ifdef MDU_MADD_EN
              3'b110, 3'b111: begin
                {tmp_hi_q, tmp_lo_q} <= {hi_q, lo_q} + prod;
                tmp_wr_q <= 1'b1;
                cnt_q    <= MULT_LAT;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q == 4'd0) begin
            if (tmp_wr_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default parameters: mult 5, div 10 cycles).
// Handshake: start is a one-cycle pulse sampled at a rising edge while busy=0; inputs driven and outputs sampled at negedge.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and count busy cycles (bounded); operands are scrambled right after the start edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int ncyc);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 40) begin
      ncyc++;
      @(negedge clk);
    end
  endtask

  task automatic write_reg(input logic [2:0] op, input logic [31:0] val);
    @(negedge clk);
    start = 1'b1; md_op = op; A = val; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
  endtask

  task automatic test_mult;
    int n;
    run_op(3'b000, 32'hFFFFFFFE, 32'd3, n);
    checks++; if (n != 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_multu;
    int n;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    checks++; if (n != 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_div;
    int n;
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (n != 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
  endtask

  task automatic test_div_zero;
    int n;
    run_op(3'b011, 32'd7, 32'd0, n);
    checks++; if (n != 10) begin failures++; $display("FAIL divz_busy got=%0d exp=10", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL divz_lo got=%h exp=fffffffd", lo); end
  endtask

  task automatic test_div_overflow;
    int n;
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, n);
    checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL divovf_hi got=%h exp=0", hi); end
    run_op(3'b011, 32'd100, 32'd7, n);
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_hilo got=%h exp=000000020000000e", {hi, lo}); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    start = 1'b1; md_op = 3'b100; A = 32'h12345678;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    md_op = 3'b101; A = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
    checks++; if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi got=%h exp=12345678", hi); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    start = 1'b1; md_op = 3'b010; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL run_hi_hold got=%h exp=12345678", hi); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin start = 1'b1; md_op = 3'b010; A = 32'd50; B = 32'd5; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (n != 10) begin failures++; $display("FAIL b2b_busy got=%0d exp=10", n); end
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_lo got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_hi got=%h exp=00000002", hi); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    start = 1'b1; md_op = 3'b010; A = 32'd7; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 4) begin
      n++;
      if (n < 4) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL rmid_hilo got=%h exp=0", {hi, lo}); end
    repeat (10) @(negedge clk);
    checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL rmid_nocommit got=%h exp=0", {hi, lo}); end
    run_op(3'b000, 32'd2, 32'd3, n);
    checks++; if (n != 5) begin failures++; $display("FAIL rmid_mult_busy got=%0d exp=5", n); end
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL rmid_mult_lo got=%h exp=00000006", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rmid_mult_hi got=%h exp=0", hi); end
  endtask

  task automatic test_madd;
    int n;
    write_reg(3'b100, 32'd0);
    write_reg(3'b101, 32'hFFFFFFFF);
    run_op(3'b110, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    checks++; if (n != 5) begin failures++; $display("FAIL madd_busy got=%0d exp=5", n); end
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL madd_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL madd_lo got=%h exp=0", lo); end
`else
    checks++; if (n != 0) begin failures++; $display("FAIL madd_nop_busy got=%0d exp=0", n); end
    repeat (6) @(negedge clk);
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL madd_nop_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL madd_nop_lo got=%h exp=ffffffff", lo); end
`endif
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_div_overflow;
    test_mthi_mtlo;
    test_back_to_back;
    test_reset_mid;
    test_madd;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
